// File: rtl/decode_issue_pkg.sv
// Shared core header: instruction field layout, K encoding, execute opcodes
// and the data/register widths used by decode and execute.
package decode_issue_pkg;

  localparam int INST_W = 16;
  localparam int DATA_W = 8;
  localparam int REG_N  = 4;
  localparam int REG_AW = 2;
  localparam int OPC_W  = 4;

  // Execute opcodes understood by the ALU
  localparam logic [OPC_W-1:0] EX_OC_MOV = 4'h1;
  localparam logic [OPC_W-1:0] EX_OC_ADD = 4'h2;

  // K bit value selecting the immediate form
  localparam logic K_IMM = 1'b1;

  // Instruction word: [15:12] opcode, [11] K, [10:9] rd, [8] reserved, [7:0] imm8
  // (rs lives in imm8[1:0] when K=0)
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic              k;
    logic [REG_AW-1:0] rd;
    logic              rsvd;
    logic [DATA_W-1:0] imm8;
  } inst_t;

  // Registered bundle handed to execute
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] source0;
    logic [DATA_W-1:0] source1;
    logic [REG_AW-1:0] dest;
  } issue_bundle_t;

  // Only MOV and ADD are issued; everything else is dropped as illegal
  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return (opc == EX_OC_MOV) || (opc == EX_OC_ADD);
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Instruction, issue and writeback signals between fetch, decode and execute.
// master = the surrounding pipeline, slave = decode_issue.
interface decode_issue_if;
  import decode_issue_pkg::*;

  logic                iINST_VALID;
  logic [INST_W-1:0]   iINST;
  logic                oINST_READY;
  logic                oVALID;
  logic                iEX_READY;
  logic [OPC_W-1:0]    oOPCODE;
  logic [DATA_W-1:0]   oSOURCE0;
  logic [DATA_W-1:0]   oSOURCE1;
  logic [REG_AW-1:0]   oDEST;
  logic                oILLEGAL;
  logic                iWB_EN;
  logic [REG_AW-1:0]   iWB_ADDR;
  logic [DATA_W-1:0]   iWB_DATA;

  modport master (
    output iINST_VALID, iINST, iEX_READY, iWB_EN, iWB_ADDR, iWB_DATA,
    input  oINST_READY, oVALID, oOPCODE, oSOURCE0, oSOURCE1, oDEST, oILLEGAL
  );

  modport slave (
    input  iINST_VALID, iINST, iEX_READY, iWB_EN, iWB_ADDR, iWB_DATA,
    output oINST_READY, oVALID, oOPCODE, oSOURCE0, oSOURCE1, oDEST, oILLEGAL
  );
endinterface

// File: rtl/decode_regfile.sv
// 4x8 register file: two combinational read ports, one write port.
// Macro DECODE_WB_BYPASS_EN: reads of the register being written this cycle
// return the incoming writeback data instead of the stored value.
module decode_regfile
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd_addr0_i,
  input  logic [REG_AW-1:0] rd_addr1_i,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // Writeback port; reset clears every register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (wb_en_i) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Read ports, optionally forwarding the in-flight writeback
  always_comb begin
    rd_data0_o = regs_q[rd_addr0_i];
    rd_data1_o = regs_q[rd_addr1_i];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en_i && (wb_addr_i == rd_addr0_i)) rd_data0_o = wb_data_i;
    if (wb_en_i && (wb_addr_i == rd_addr1_i)) rd_data1_o = wb_data_i;
`endif
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes MOV/ADD, reads operands, tracks pending
// destinations in a scoreboard and holds a registered bundle for execute.
// Macro DECODE_WB_BYPASS_EN: a same-cycle writeback resolves the hazard and
// forwards its data into the issued operands.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic          iCLK,
  input  logic          iRST_N,
  decode_issue_if.slave bus
);

  inst_t             inst;
  logic [REG_AW-1:0] rs;
  logic              is_imm;
  logic [DATA_W-1:0] rf_data0;
  logic [DATA_W-1:0] rf_data1;
  logic              wb_hit_rd;
  logic              wb_hit_rs;
  logic              stall;
  logic              inst_ready;
  logic              accept;
  logic              issue;
  logic [REG_N-1:0]  sb_q;
  logic [REG_N-1:0]  sb_d;
  logic              valid_q;
  logic              illegal_q;
  issue_bundle_t     bundle_q;
  logic              unused_rsvd;

  assign inst        = inst_t'(bus.iINST);
  assign rs          = inst.imm8[REG_AW-1:0];
  assign is_imm      = (inst.k == K_IMM);
  assign unused_rsvd = inst.rsvd;

  decode_regfile u_regfile (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .rd_addr0_i (inst.rd),
    .rd_addr1_i (rs),
    .rd_data0_o (rf_data0),
    .rd_data1_o (rf_data1),
    .wb_en_i    (bus.iWB_EN),
    .wb_addr_i  (bus.iWB_ADDR),
    .wb_data_i  (bus.iWB_DATA)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign wb_hit_rd = bus.iWB_EN && (bus.iWB_ADDR == inst.rd);
  assign wb_hit_rs = bus.iWB_EN && (bus.iWB_ADDR == rs);
`else
  assign wb_hit_rd = 1'b0;
  assign wb_hit_rs = 1'b0;
`endif

  // Hazard: pending rd, or pending rs for the register form only
  assign stall = (sb_q[inst.rd] & ~wb_hit_rd) | (~is_imm & sb_q[rs] & ~wb_hit_rs);

  // Ready ignores iINST_VALID; forced high while reset is asserted
  assign inst_ready = ~iRST_N | (~stall & (~valid_q | bus.iEX_READY));
  assign accept     = bus.iINST_VALID & inst_ready;
  assign issue      = accept & is_legal(inst.opcode);

  // Scoreboard next state: writeback clears, a new issue sets (set wins)
  always_comb begin
    sb_d = sb_q;
    if (bus.iWB_EN) sb_d[bus.iWB_ADDR] = 1'b0;
    if (issue)      sb_d[inst.rd]      = 1'b1;
  end

  // Output register, valid flag, illegal pulse and scoreboard
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sb_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      bundle_q  <= '0;
    end else begin
      sb_q      <= sb_d;
      illegal_q <= accept & ~is_legal(inst.opcode);
      if (issue) begin
        valid_q          <= 1'b1;
        bundle_q.opcode  <= inst.opcode;
        bundle_q.source0 <= rf_data0;
        bundle_q.source1 <= is_imm ? inst.imm8 : rf_data1;
        bundle_q.dest    <= inst.rd;
      end else if (bus.iEX_READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.oINST_READY = inst_ready;
  assign bus.oVALID      = valid_q;
  assign bus.oOPCODE     = bundle_q.opcode;
  assign bus.oSOURCE0    = bundle_q.source0;
  assign bus.oSOURCE1    = bundle_q.source1;
  assign bus.oDEST       = bundle_q.dest;
  assign bus.oILLEGAL    = illegal_q;

endmodule
